// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: opcodes, instruction field positions and drain FSM encoding.
package dlx_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDUI = 6'h09;
   localparam logic [5:0] OP_SUBI  = 6'h0A;
   localparam logic [5:0] OP_SUBUI = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int unsigned OP_MSB = 31;
   localparam int unsigned OP_LSB = 26;
   localparam int unsigned RS_MSB = 25;
   localparam int unsigned RS_LSB = 21;
   localparam int unsigned RT_MSB = 20;
   localparam int unsigned RT_LSB = 16;
   localparam int unsigned RD_MSB = 15;
   localparam int unsigned RD_LSB = 11;

   localparam logic [4:0] REG_LINK = 5'd31;

   typedef enum logic [1:0] {
      DRN_IDLE  = 2'd0,
      DRN_DRAIN = 2'd1,
      DRN_DONE  = 2'd2
   } drain_state_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier: which source fields are read and which GPR is written.
module instr_class_decode
   import dlx_pkg::*;
(
   input  logic [31:0] instruc,
   output logic        rs_rd_en,
   output logic        rt_rd_en,
   output logic        dest_valid,
   output logic [4:0]  dest
);

   logic [5:0] op;
   logic [4:0] rt;
   logic [4:0] rd;
   logic       has_wr;
   logic [4:0] raw_dest;
   logic       unused_bits;

   assign op          = instruc[OP_MSB:OP_LSB];
   assign rt          = instruc[RT_MSB:RT_LSB];
   assign rd          = instruc[RD_MSB:RD_LSB];
   assign unused_bits = ^{instruc[RS_MSB:RS_LSB], instruc[10:0]};

   always_comb begin
      rs_rd_en = 1'b0;
      rt_rd_en = 1'b0;
      has_wr   = 1'b0;
      raw_dest = '0;
      case (op)
         OP_RTYPE: begin
            rs_rd_en = 1'b1;
            rt_rd_en = 1'b1;
            has_wr   = 1'b1;
            raw_dest = rd;
         end
         OP_ADDI, OP_ADDUI, OP_SUBI, OP_SUBUI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
            rs_rd_en = 1'b1;
            has_wr   = 1'b1;
            raw_dest = rt;
         end
         OP_LUI: begin
            has_wr   = 1'b1;
            raw_dest = rt;
         end
         OP_SW, OP_BEQ, OP_BNE: begin
            rs_rd_en = 1'b1;
            rt_rd_en = 1'b1;
         end
         OP_JAL: begin
            has_wr   = 1'b1;
            raw_dest = REG_LINK;
         end
         default: ;
      endcase
   end

   // $0 is a sink: writing it is not a real destination
   assign dest_valid = has_wr & (raw_dest != 5'd0);
   assign dest       = dest_valid ? raw_dest : '0;

endmodule

// File: rtl/id_scoreboard.sv
// DLX ID-stage register scoreboard, hazard stall/issue control and drain handshake.
// Optional stall counter output enabled by defining ID_SCOREBOARD_STALL_CNT_EN.
module id_scoreboard
   import dlx_pkg::*;
#(
   parameter int unsigned BYPASS = 1,
   parameter int unsigned NREG   = 32
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] instruc,
   input  logic        flush,
   input  logic        wb_en,
   input  logic [4:0]  rw,
   input  logic        drain_req,
   output logic        stall,
   output logic        issue,
   output logic        dest_valid,
   output logic [4:0]  dest,
   output logic [31:0] busy,
   output logic        drain_ack
`ifdef ID_SCOREBOARD_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam logic [31:0] TRACK_MASK =
      ((NREG >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NREG) - 32'd1)) & 32'hFFFF_FFFE;

   logic [31:0]  busy_q;
   logic [31:0]  busy_nxt;
   drain_state_t state_q;
   logic         ack_q;

   logic         dec_rs_en;
   logic         dec_rt_en;
   logic         dec_dv;
   logic [4:0]   dec_dest;
   logic [4:0]   rs;
   logic [4:0]   rt;
   logic         byp_en;
   logic         rs_haz;
   logic         rt_haz;
   logic         waw_haz;
   logic         hazard;
   logic         drain_hold;

   instr_class_decode u_decode (
      .instruc    (instruc),
      .rs_rd_en   (dec_rs_en),
      .rt_rd_en   (dec_rt_en),
      .dest_valid (dec_dv),
      .dest       (dec_dest)
   );

   assign rs     = instruc[RS_MSB:RS_LSB];
   assign rt     = instruc[RT_MSB:RT_LSB];
   assign byp_en = (BYPASS != 0);

   // Write-first regfile lets a same-cycle writeback satisfy a read; never a pending write
   assign rs_haz  = dec_rs_en & busy_q[rs] & ~(byp_en & wb_en & (rw == rs));
   assign rt_haz  = dec_rt_en & busy_q[rt] & ~(byp_en & wb_en & (rw == rt));
   assign waw_haz = dec_dv & busy_q[dec_dest];
   assign hazard  = id_valid & (rs_haz | rt_haz | waw_haz);

   assign drain_hold = (state_q != DRN_IDLE);

   assign stall      = rst_n & ~flush & (hazard | (id_valid & drain_hold));
   assign issue      = rst_n & id_valid & ~hazard & ~flush & ~drain_hold;
   assign dest_valid = issue & dec_dv;
   assign dest       = dest_valid ? dec_dest : '0;
   assign busy       = busy_q;
   assign drain_ack  = ack_q;

   // Set is applied after clear so an issue to a retiring register keeps it busy
   always_comb begin
      busy_nxt = busy_q;
      if (wb_en) begin
         busy_nxt[rw] = 1'b0;
      end
      if (dest_valid) begin
         busy_nxt[dec_dest] = 1'b1;
      end
      busy_nxt = busy_nxt & TRACK_MASK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DRN_IDLE;
         ack_q   <= 1'b0;
      end else begin
         case (state_q)
            DRN_IDLE: begin
               ack_q <= 1'b0;
               if (drain_req) begin
                  state_q <= DRN_DRAIN;
               end
            end
            DRN_DRAIN: begin
               if (busy_q == '0) begin
                  state_q <= DRN_DONE;
                  ack_q   <= 1'b1;
               end
            end
            DRN_DONE: begin
               if (!drain_req) begin
                  state_q <= DRN_IDLE;
                  ack_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= DRN_IDLE;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef ID_SCOREBOARD_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: bypass and non-bypass instances against a reference model.
module tb_id_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] instruc;
   logic        flush;
   logic        wb_en;
   logic [4:0]  rw;
   logic        drain_req;

   logic        o_stall [2];
   logic        o_issue [2];
   logic        o_dv    [2];
   logic [4:0]  o_dest  [2];
   logic [31:0] o_busy  [2];
   logic        o_ack   [2];
`ifdef ID_SCOREBOARD_STALL_CNT_EN
   logic [31:0] o_cnt   [2];
`endif

   int ncmp;
   int nfail;

   // reference model state, index 0 = BYPASS 1, index 1 = BYPASS 0
   logic [31:0] m_busy [2];
   int          m_st   [2];
   logic        m_ack  [2];
   logic [31:0] m_cnt  [2];
   logic        e_stall [2];
   logic        e_issue [2];
   logic        e_dv    [2];
   logic [4:0]  e_dest  [2];

   id_scoreboard #(.BYPASS(1), .NREG(32)) u_dut_byp (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .instruc    (instruc),
      .flush      (flush),
      .wb_en      (wb_en),
      .rw         (rw),
      .drain_req  (drain_req),
      .stall      (o_stall[0]),
      .issue      (o_issue[0]),
      .dest_valid (o_dv[0]),
      .dest       (o_dest[0]),
      .busy       (o_busy[0]),
      .drain_ack  (o_ack[0])
`ifdef ID_SCOREBOARD_STALL_CNT_EN
      ,
      .stall_cnt  (o_cnt[0])
`endif
   );

   id_scoreboard #(.BYPASS(0), .NREG(32)) u_dut_nob (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .instruc    (instruc),
      .flush      (flush),
      .wb_en      (wb_en),
      .rw         (rw),
      .drain_req  (drain_req),
      .stall      (o_stall[1]),
      .issue      (o_issue[1]),
      .dest_valid (o_dv[1]),
      .dest       (o_dest[1]),
      .busy       (o_busy[1]),
      .drain_ack  (o_ack[1])
`ifdef ID_SCOREBOARD_STALL_CNT_EN
      ,
      .stall_cnt  (o_cnt[1])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s[%0d]: observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // Operand usage straight from the ISA table
   function automatic void classify(input logic [31:0] ins, output logic rd_a, output logic rd_b,
                                    output logic [4:0] ra, output logic [4:0] rb,
                                    output logic wr, output logic [4:0] wreg);
      int op;
      op   = int'(ins[31:26]);
      ra   = ins[25:21];
      rb   = ins[20:16];
      rd_a = 1'b0;
      rd_b = 1'b0;
      wr   = 1'b0;
      wreg = 5'd0;
      if (op == 0) begin
         rd_a = 1'b1; rd_b = 1'b1; wr = 1'b1; wreg = ins[15:11];
      end else if ((op >= 8 && op <= 14) || op == 35) begin
         rd_a = 1'b1; wr = 1'b1; wreg = ins[20:16];
      end else if (op == 15) begin
         wr = 1'b1; wreg = ins[20:16];
      end else if (op == 43 || op == 4 || op == 5) begin
         rd_a = 1'b1; rd_b = 1'b1;
      end else if (op == 3) begin
         wr = 1'b1; wreg = 5'd31;
      end
   endfunction

   task automatic check();
      logic rd_a, rd_b, wr, hz, hold;
      logic [4:0] ra, rb, wreg;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_busy[k] = '0;
            m_st[k]   = 0;
            m_ack[k]  = 1'b0;
            m_cnt[k]  = '0;
         end
         classify(instruc, rd_a, rd_b, ra, rb, wr, wreg);
         hz = 1'b0;
         if (rd_a && ra != 0 && m_busy[k][ra] && !(k == 0 && wb_en && rw == ra)) hz = 1'b1;
         if (rd_b && rb != 0 && m_busy[k][rb] && !(k == 0 && wb_en && rw == rb)) hz = 1'b1;
         if (wr && wreg != 0 && m_busy[k][wreg]) hz = 1'b1;
         hz   = hz & id_valid;
         hold = (m_st[k] != 0);
         e_stall[k] = rst_n & ~flush & (hz | (id_valid & hold));
         e_issue[k] = rst_n & id_valid & ~hz & ~flush & ~hold;
         e_dv[k]    = e_issue[k] & wr & (wreg != 0);
         e_dest[k]  = e_dv[k] ? wreg : 5'd0;
         chk("stall", k, 32'(o_stall[k]), 32'(e_stall[k]));
         chk("issue", k, 32'(o_issue[k]), 32'(e_issue[k]));
         chk("dest_valid", k, 32'(o_dv[k]), 32'(e_dv[k]));
         chk("dest", k, 32'(o_dest[k]), 32'(e_dest[k]));
         chk("busy", k, o_busy[k], m_busy[k]);
         chk("drain_ack", k, 32'(o_ack[k]), 32'(m_ack[k]));
`ifdef ID_SCOREBOARD_STALL_CNT_EN
         chk("stall_cnt", k, o_cnt[k], m_cnt[k]);
`endif
      end
   endtask

   task automatic update();
      logic [31:0] nb;
      for (int k = 0; k < 2; k++) begin
         if (rst_n) begin
            nb = m_busy[k];
            if (wb_en) nb[rw] = 1'b0;
            if (e_dv[k]) nb[e_dest[k]] = 1'b1;
            nb[0] = 1'b0;
            case (m_st[k])
               0: if (drain_req) m_st[k] = 1;
               1: if (m_busy[k] == 0) begin m_st[k] = 2; m_ack[k] = 1'b1; end
               default: if (!drain_req) begin m_st[k] = 0; m_ack[k] = 1'b0; end
            endcase
            if (e_stall[k] && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 1;
            m_busy[k] = nb;
         end
      end
   endtask

   // Called just after a falling edge with inputs already applied
   task automatic step();
      #1;
      check();
      @(posedge clk);
      update();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic f,
                        input logic w, input logic [4:0] r, input logic d);
      id_valid  = v;
      instruc   = ins;
      flush     = f;
      wb_en     = w;
      rw        = r;
      drain_req = d;
      step();
   endtask

   task automatic clear_all();
      for (int r = 1; r < 32; r++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b1, 5'(r), 1'b0);
      end
   endtask

   logic [5:0] ops [12];

   initial begin
      ncmp = 0;
      nfail = 0;
      ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h11};
      rst_n = 1'b0;
      id_valid = 1'b0; instruc = '0; flush = 1'b0; wb_en = 1'b0; rw = '0; drain_req = 1'b0;
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);

      // add $3,$1,$2 then observe busy[3]
      drive(1'b1, 32'h0022_1820, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      // RAW on $3: stall, then writeback same cycle, then one more cycle
      drive(1'b1, 32'h0063_2020, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, 32'h0063_2020, 1'b0, 1'b1, 5'd3, 1'b0);
      drive(1'b1, 32'h0063_2020, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, 32'h0063_2020, 1'b1, 1'b0, 5'd0, 1'b0);
      clear_all();

      // lw $5: WAW stall against pending $5, then set-wins against a harmless writeback
      drive(1'b1, 32'h8C05_0000, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, 32'h8C05_0000, 1'b0, 1'b1, 5'd5, 1'b0);
      drive(1'b1, 32'h8C05_0000, 1'b0, 1'b1, 5'd5, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      // dest $0 and an undefined opcode
      drive(1'b1, 32'h0001_0020, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, 32'h0C00_0000, 1'b0, 1'b0, 5'd0, 1'b0);
      clear_all();

      // drain with busy = 0x30
      drive(1'b1, 32'h8C04_0000, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, 32'h8C05_0000, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 5'd0, 1'b1);
      drive(1'b1, 32'hFC00_0000, 1'b0, 1'b1, 5'd4, 1'b1);
      drive(1'b1, 32'hFC00_0000, 1'b0, 1'b1, 5'd5, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 5'd0, 1'b1);
      drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 5'd0, 1'b0);

      // fill $1..$7, enter DRAIN, reset asynchronously mid-cycle
      for (int r = 1; r < 8; r++) drive(1'b1, 32'h8C00_0000 | (32'(r) << 16), 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
      drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 5'd0, 1'b1);
      rst_n = 1'b0;
      drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 5'd0, 1'b1);
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);

      // seven consecutive RAW stalls on $3
      drive(1'b1, 32'h0022_1820, 1'b0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b1, 32'h0063_2020, 1'b0, 1'b0, 5'd0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      clear_all();

      // randomized traffic on a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins;
         logic        d;
         ins = {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'h020};
         d = drain_req;
         if (!d && $urandom_range(0, 39) == 0) d = 1'b1;
         else if (d && $urandom_range(0, 7) == 0) d = 1'b0;
         drive(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
